// File: rtl/seq_scale_mult.sv
// Unsigned radix-2 shift-and-add multiplier, dout = din * scale saturated to OUT_WIDTH bits.
// Latency: dout_valid rises SCALE_WIDTH cycles after the accepting edge; initiation interval SCALE_WIDTH+2.
// Backpressure: result held in DONE until dout_ready; din_ready low from accept until the cycle after the output handshake.
module seq_scale_mult #(
    parameter int IN_WIDTH    = 32,
    parameter int SCALE_WIDTH = 8,
    parameter int OUT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [IN_WIDTH-1:0]    din,
    input  logic [SCALE_WIDTH-1:0] scale,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [OUT_WIDTH-1:0]   dout,
    output logic                   dout_sat
);

    localparam int PW = IN_WIDTH + SCALE_WIDTH;
    localparam int CW = (SCALE_WIDTH > 1) ? $clog2(SCALE_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SCALE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IN_WIDTH-1:0]    din_reg;
    logic [SCALE_WIDTH-1:0] scale_reg;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          acc_nxt;
    logic [PW-1:0]          addend;
    logic [CW-1:0]          cnt;
    logic                   last_iter;
    logic [OUT_WIDTH-1:0]   sat_dat;
    logic                   sat_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_iter = (state == RUN) && (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (din_valid) state_nxt = RUN;
            RUN:  if (last_iter) state_nxt = DONE;
            DONE: if (dout_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One partial product per cycle; the full-width sum is what saturation inspects.
    assign addend  = scale_reg[0] ? (PW'(din_reg) << cnt) : '0;
    assign acc_nxt = acc + addend;

    generate
        if (OUT_WIDTH >= PW) begin : g_nosat
            assign sat_dat  = OUT_WIDTH'(acc_nxt);
            assign sat_flag = 1'b0;
        end else begin : g_sat
            logic ovf;
            assign ovf      = |acc_nxt[PW-1:OUT_WIDTH];
            assign sat_dat  = ovf ? '1 : acc_nxt[OUT_WIDTH-1:0];
            assign sat_flag = ovf;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_reg   <= '0;
            scale_reg <= '0;
            acc       <= '0;
            cnt       <= '0;
            dout      <= '0;
            dout_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        din_reg   <= din;
                        scale_reg <= scale;
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    acc       <= acc_nxt;
                    scale_reg <= scale_reg >> 1;
                    cnt       <= cnt + CW'(1);
                    if (last_iter) begin
                        dout     <= sat_dat;
                        dout_sat <= sat_flag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign din_ready  = (state == IDLE);
    assign dout_valid = (state == DONE);

endmodule

// File: tb/tb_seq_scale_mult.sv
// Bench for seq_scale_mult: vector table, random operands against an arithmetic model, and handshake corner sequences.
module tb_seq_scale_mult;

    localparam int IW  = 32;
    localparam int SW  = 8;
    localparam int OW  = 32;
    localparam int LAT = SW;

    logic          clk = 1'b0;
    logic          reset;
    logic          din_valid;
    logic          din_ready;
    logic [IW-1:0] din;
    logic [SW-1:0] scale;
    logic          dout_valid;
    logic          dout_ready;
    logic [OW-1:0] dout;
    logic          dout_sat;

    int errors = 0;
    int checks = 0;

    seq_scale_mult #(.IN_WIDTH(IW), .SCALE_WIDTH(SW), .OUT_WIDTH(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .scale      (scale),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_sat   (dout_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] a;
        logic [SW-1:0] s;
        logic [OW-1:0] exp_dout;
        logic          exp_sat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: exact product in 64 bits, clamped to the output range.
    function automatic logic [OW:0] model(input logic [IW-1:0] a, input logic [SW-1:0] s);
        longint unsigned p;
        longint unsigned maxv;
        p    = longint'(a) * longint'(s);
        maxv = (64'd1 << OW) - 64'd1;
        if (p > maxv) return {1'b1, OW'(maxv)};
        return {1'b0, OW'(p)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with dout_ready high; checks latency, result and return to idle.
    task automatic run_op(input logic [IW-1:0] a, input logic [SW-1:0] s,
                          input logic [OW-1:0] ed, input logic es, input string nm);
        int n;
        din_valid = 1'b1;
        din       = a;
        scale     = s;
        dout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = '0;
        scale     = '0;
        chk({nm, "_rdy_low"}, 64'(din_ready), 64'd0);
        n = 0;
        while (!dout_valid && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(LAT));
        chk({nm, "_dout"}, 64'(dout), 64'(ed));
        chk({nm, "_sat"}, 64'(dout_sat), 64'(es));
        tick();
        chk({nm, "_vld_drop"}, 64'(dout_valid), 64'd0);
        chk({nm, "_rdy_back"}, 64'(din_ready), 64'd1);
    endtask

    initial begin
        logic [OW:0] m;
        logic [IW-1:0] ra;
        logic [SW-1:0] rs;
        int n;

        vecs[0] = '{32'd1000,       8'd25,  32'd25000,      1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  8'd2,   32'hFFFF_FFFF,  1'b1};
        vecs[2] = '{32'h8000_0000,  8'd1,   32'h8000_0000,  1'b0};
        vecs[3] = '{32'h8000_0000,  8'd2,   32'hFFFF_FFFF,  1'b1};
        vecs[4] = '{32'h0000_1234,  8'd0,   32'd0,          1'b0};
        vecs[5] = '{32'hDEAD_BEEF,  8'd1,   32'hDEAD_BEEF,  1'b0};
        vecs[6] = '{32'd0,          8'd255, 32'd0,          1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  8'd255, 32'hFFFF_FFFF,  1'b1};
        vecs[8] = '{32'h00FF_FFFF,  8'd255, 32'hFEFF_FF01,  1'b0};
        vecs[9] = '{32'd1,          8'd128, 32'd128,        1'b0};

        reset      = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        scale      = '0;
        dout_ready = 1'b0;
        repeat (3) tick();
        chk("rst_din_ready", 64'(din_ready), 64'd1);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_sat", 64'(dout_sat), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].s, vecs[i].exp_dout, vecs[i].exp_sat, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ra = (i % 3 == 0) ? IW'($urandom_range(0, 65535)) : IW'($urandom);
            rs = SW'($urandom);
            m  = model(ra, rs);
            run_op(ra, rs, m[OW-1:0], m[OW], $sformatf("rnd%0d", i));
        end

        // Backpressure: result must hold and new operands must be ignored.
        din_valid  = 1'b1;
        din        = 32'd7;
        scale      = 8'd9;
        dout_ready = 1'b0;
        tick();
        din_valid = 1'b0;
        n = 0;
        while (!dout_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_latency", 64'(n), 64'(LAT));
        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1;
            din       = 32'd99;
            scale     = 8'd99;
            tick();
            din_valid = 1'b0;
            chk($sformatf("bp_hold_vld%0d", i), 64'(dout_valid), 64'd1);
            chk($sformatf("bp_hold_dout%0d", i), 64'(dout), 64'd63);
            chk($sformatf("bp_hold_rdy%0d", i), 64'(din_ready), 64'd0);
        end
        dout_ready = 1'b1;
        tick();
        chk("bp_release_vld", 64'(dout_valid), 64'd0);
        chk("bp_release_rdy", 64'(din_ready), 64'd1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dout_valid) n++;
        end
        chk("bp_no_ghost", 64'(n), 64'd0);

        // Reset three cycles into RUN aborts the operation.
        din_valid = 1'b1;
        din       = 32'd100;
        scale     = 8'd3;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", 64'(din_ready), 64'd1);
        chk("mid_rst_vld", 64'(dout_valid), 64'd0);
        chk("mid_rst_dout", 64'(dout), 64'd0);
        chk("mid_rst_sat", 64'(dout_sat), 64'd0);
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dout_valid) n++;
        end
        chk("mid_rst_no_result", 64'(n), 64'd0);
        run_op(32'd5, 8'd6, 32'd30, 1'b0, "post_rst");

        // Back-to-back stream with din_valid held high.
        begin
            logic [IW-1:0] sa[3];
            logic [SW-1:0] ss[3];
            logic [OW:0]   expq[$];
            int idx, nout, last_out, rdy_prev;
            sa[0] = 32'd3;         ss[0] = 8'd4;
            sa[1] = 32'd255;       ss[1] = 8'd255;
            sa[2] = 32'hFFFF_FFFF; ss[2] = 8'hFF;
            idx = 0; nout = 0; last_out = -1;
            dout_ready = 1'b1;
            din_valid  = 1'b1;
            din        = sa[0];
            scale      = ss[0];
            rdy_prev   = int'(din_ready);
            for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
                @(posedge clk);
                if (rdy_prev != 0 && din_valid) begin
                    m = model(sa[idx], ss[idx]);
                    expq.push_back(m);
                    idx++;
                end
                #1;
                if (idx < 3) begin
                    din   = sa[idx];
                    scale = ss[idx];
                end else begin
                    din_valid = 1'b0;
                end
                rdy_prev = int'(din_ready);
                if (dout_valid) begin
                    m = (expq.size() > 0) ? expq.pop_front() : '1;
                    chk($sformatf("b2b_dout%0d", nout), 64'(dout), 64'(m[OW-1:0]));
                    chk($sformatf("b2b_sat%0d", nout), 64'(dout_sat), 64'(m[OW]));
                    if (last_out >= 0)
                        chk($sformatf("b2b_spacing%0d", nout), 64'(cyc - last_out), 64'(SW + 2));
                    last_out = cyc;
                    nout++;
                end
            end
            din_valid = 1'b0;
            chk("b2b_count", 64'(nout), 64'd3);
            chk("b2b_model_12", 64'(model(32'd3, 8'd4)), 64'd12);
            chk("b2b_model_65025", 64'(model(32'd255, 8'd255)), 64'd65025);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_scale_mult.md
Name: seq_scale_mult

Overview:
- Sequential unsigned multiplier: dout = din × scale, saturated to OUT_WIDTH bits.
- It is the upscaling counterpart of the rounding power-of-two divider.
- Radix-2 shift-and-add, one scale bit per cycle.
- Valid/ready handshake on both sides; sits in the datapath where narrowed quantities are re-expanded by a runtime gain.

Parameters:
- IN_WIDTH, 32, width of din.
- SCALE_WIDTH, 8, width of scale; also the iteration count.
- OUT_WIDTH, 32, width of dout. Must be ≥ IN_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din_valid  input  1  operand pair valid.
- din_ready  output  1  block can accept operands.
- din  input  IN_WIDTH  multiplicand, unsigned.
- scale  input  SCALE_WIDTH  multiplier, unsigned.
- dout_valid  output  1  result valid.
- dout_ready  input  1  consumer accepts result.
- dout  output  OUT_WIDTH  saturated product.
- dout_sat  output  1  high when dout was clamped.

Behaviour:
- Reset (async, any state) values:
  - state=IDLE, din_ready=1, dout_valid=0, dout=0, dout_sat=0.
  - Internal accumulator, operand registers and counter cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and never presented.
- IDLE:
  - din_ready=1, dout_valid=0.
  - On a clock edge with din_valid=1: latch din and scale, clear the accumulator (width IN_WIDTH+SCALE_WIDTH), counter=0, go to RUN.
  - din and scale are not sampled again until the next IDLE.
- RUN:
  - din_ready=0, dout_valid=0.
  - Each edge: if the scale register LSB is 1, acc += (din_reg << counter). Then scale_reg >>= 1 and counter++.
  - Exactly SCALE_WIDTH iterations, fixed latency; no early exit on zero scale.
  - On the edge performing the final iteration, go to DONE and register dout/dout_sat from the final full product.
- Saturation:
  - P = full product (IN_WIDTH+SCALE_WIDTH bits).
  - If P > 2^OUT_WIDTH−1: dout = all ones, dout_sat=1. Otherwise dout = P[OUT_WIDTH-1:0], dout_sat=0.
  - When OUT_WIDTH ≥ IN_WIDTH+SCALE_WIDTH, dout_sat is constant 0.
- DONE:
  - dout_valid=1, din_ready=0.
  - dout and dout_sat held stable while dout_valid=1 and dout_ready=0 (backpressure of any length).
  - On an edge with dout_ready=1: go to IDLE, dout_valid→0. dout/dout_sat keep their last value (don't-care to consumers).
- Latency and throughput:
  - Accepting edge at T0 → dout_valid high after edge T0+SCALE_WIDTH.
  - With dout_ready held high, dout_valid is high for exactly one cycle.
  - din_ready returns high the cycle after the output handshake.
  - No same-cycle output handshake plus new accept: minimum initiation interval is SCALE_WIDTH+2 cycles.
- Signal rules:
  - din_valid while din_ready=0 is ignored; the producer must hold it.
  - dout_ready while dout_valid=0 has no effect.
  - All outputs are registered; no combinational path from inputs to outputs.
- Boundaries:
  - scale=0 → dout=0, sat=0.
  - din=0 → dout=0.
  - Maximum operands saturate unless widths allow the full product.

Test Plan:
- Defaults. din=1000, scale=25, dout_ready=1 → dout_valid exactly 8 cycles after the accept edge, dout=25000, dout_sat=0, din_ready high the following cycle.
- Saturation. din=0xFFFF_FFFF, scale=2 → dout=0xFFFF_FFFF, dout_sat=1. din=0x8000_0000, scale=1 → dout=0x8000_0000, dout_sat=0. din=0x8000_0000, scale=2 → dout_sat=1.
- Zero and identity. scale=0, din=0x1234 → dout=0. scale=1, din=0xDEAD_BEEF → dout=0xDEAD_BEEF. Latency is still 8 cycles in both cases.
- Backpressure. din=7, scale=9, dout_ready=0 for 5 cycles after dout_valid → dout=63 held stable, din_valid pulses ignored with din_ready=0. Raise dout_ready → one handshake, then IDLE.
- Reset mid-operation. Assert reset 3 cycles into RUN for din=100, scale=3 → outputs go to reset values immediately and no dout_valid follows. Then din=5, scale=6 → dout=30.
- Back-to-back. din_valid held high with a stream of (3,4), (255,255), (0xFFFF_FFFF,0xFF) → results 12, 65025, 0xFFFF_FFFF with sat=1, each spaced SCALE_WIDTH+2 cycles apart.
